// File: rtl/bus_master_ctrl_pkg.sv
// Shared definitions for the WR_n/RD_n bus initiator: phase encodings,
// strobe levels and a small sizing helper.
package bus_master_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_STROBE = 2'd2,
      S_HOLD   = 2'd3
   } state_e;

   // Bus strobes are active low.
   localparam logic STROBE_ON  = 1'b0;
   localparam logic STROBE_OFF = 1'b1;

   // Largest of three phase lengths, used to size the phase counter.
   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/bus_master_ctrl_phase_timer.sv
// Loadable down-counter that flags the final cycle of a bus phase.
// Loaded with (N-1) on phase entry; last_cyc is high once the count hits 0.
module bus_master_ctrl_phase_timer #(
   parameter int unsigned CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             last_cyc
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             last_q, last_d;

   // Reload on phase entry, otherwise count down and park at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
      last_d = (cnt_d == '0);
   end

   // Counter and registered last-cycle flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         last_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         last_q <= last_d;
      end
   end

   assign last_cyc = last_q;

endmodule

// File: rtl/bus_master_ctrl.sv
// Initiator for the WR_n/RD_n parallel peripheral bus: accepts one request,
// runs setup / strobe / hold phases and returns a one-cycle response.
module bus_master_ctrl
   import bus_master_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned SETUP_CYC  = 1,
   parameter int unsigned STROBE_CYC = 2,
   parameter int unsigned HOLD_CYC   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] ADDR,
   output logic [DATA_W-1:0] DOUT,
   output logic              DOE,
   input  logic [DATA_W-1:0] DIN,
   output logic              WR_n,
   output logic              RD_n,
   output logic              busy
);

   localparam int unsigned CNT_W = $clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC) + 1);
   localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'((HOLD_CYC == 0) ? 0 : HOLD_CYC - 1);

   state_e            state_q, state_d;
   logic              tmr_load;
   logic [CNT_W-1:0]  tmr_val;
   logic              tmr_last;
   logic              accept;

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              we_q, we_d;
   logic              doe_q, doe_d;
   logic              wr_n_q, wr_n_d;
   logic              rd_n_q, rd_n_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;

   bus_master_ctrl_phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .last_cyc (tmr_last)
   );

   // Phase state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Phase sequencing; each phase entry reloads the timer.
   always_comb begin
      state_d  = state_q;
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               state_d  = S_SETUP;
               tmr_load = 1'b1;
               tmr_val  = SETUP_LD;
            end
         end
         S_SETUP: begin
            if (tmr_last) begin
               state_d  = S_STROBE;
               tmr_load = 1'b1;
               tmr_val  = STROBE_LD;
            end
         end
         S_STROBE: begin
            if (tmr_last) begin
               if (HOLD_CYC == 0) begin
                  state_d = S_IDLE;
               end else begin
                  state_d  = S_HOLD;
                  tmr_load = 1'b1;
                  tmr_val  = HOLD_LD;
               end
            end
         end
         S_HOLD: begin
            if (tmr_last) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Next values of the bus pins and response, derived from the upcoming phase.
   always_comb begin
      accept      = (state_q == S_IDLE) && req_valid;
      addr_d      = addr_q;
      dout_d      = dout_q;
      we_d        = we_q;
      rdata_d     = rdata_q;
      if (accept) begin
         addr_d = req_addr;
         dout_d = req_wdata;
         we_d   = req_we;
      end
      doe_d       = (state_d != S_IDLE) && we_d;
      wr_n_d      = ((state_d == S_STROBE) &&  we_d) ? STROBE_ON : STROBE_OFF;
      rd_n_d      = ((state_d == S_STROBE) && !we_d) ? STROBE_ON : STROBE_OFF;
      rsp_valid_d = (state_q != S_IDLE) && (state_d == S_IDLE);
      if ((state_q == S_STROBE) && tmr_last && !we_q) begin
         rdata_d = DIN;
      end
      ready_d     = (state_d == S_IDLE);
      busy_d      = (state_d != S_IDLE);
   end

   // Output and transfer registers; reset also aborts any bus cycle in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q      <= '0;
         dout_q      <= '0;
         we_q        <= 1'b0;
         rdata_q     <= '0;
         doe_q       <= 1'b0;
         wr_n_q      <= STROBE_OFF;
         rd_n_q      <= STROBE_OFF;
         rsp_valid_q <= 1'b0;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         addr_q      <= addr_d;
         dout_q      <= dout_d;
         we_q        <= we_d;
         rdata_q     <= rdata_d;
         doe_q       <= doe_d;
         wr_n_q      <= wr_n_d;
         rd_n_q      <= rd_n_d;
         rsp_valid_q <= rsp_valid_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
      end
   end

   assign req_ready = ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;
   assign ADDR      = addr_q;
   assign DOUT      = dout_q;
   assign DOE       = doe_q;
   assign WR_n      = wr_n_q;
   assign RD_n      = rd_n_q;
   assign busy      = busy_q;

endmodule
